// File: rtl/dm_multi_hart_ctrl.sv
// rtl/dm_multi_hart_ctrl.sv - multi-hart debug module core: DMI register file, halt/resume fan-out, abstract command engine
module dm_multi_hart_ctrl #(
  parameter int NUM_HARTS = 4,
  parameter int REGADDR_W = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           dmi_req_op_i,
  input  logic [31:0]          dmi_req_data_i,
  input  logic [6:0]           dmi_req_address_i,
  input  logic                 dmi_req_valid_i,
  output logic                 dmi_req_ready_o,
  output logic                 dmi_rsp_valid_o,
  output logic [31:0]          dmi_rsp_data_o,
  output logic [1:0]           dmi_rsp_op_o,
  output logic [NUM_HARTS-1:0] hart_halt_req_o,
  input  logic [NUM_HARTS-1:0] hart_halt_ack_i,
  output logic [NUM_HARTS-1:0] hart_resume_req_o,
  input  logic [NUM_HARTS-1:0] hart_resume_ack_i,
  output logic                 hart_reg_en_o,
  output logic                 hart_reg_wr_o,
  output logic [NUM_HARTS-1:0] hart_reg_sel_o,
  output logic [REGADDR_W-1:0] hart_reg_addr_o,
  output logic [31:0]          hart_reg_wdata_o,
  input  logic [31:0]          hart_reg_rdata_i,
  input  logic                 hart_reg_done_i
);

  typedef enum logic {S_IDLE, S_RSP} dmi_state_t;
  typedef enum logic {E_IDLE, E_ACC} eng_state_t;

  localparam logic [6:0] A_DATA0   = 7'h04;
  localparam logic [6:0] A_DMCTRL  = 7'h10;
  localparam logic [6:0] A_DMSTAT  = 7'h11;
  localparam logic [6:0] A_ABSCS   = 7'h16;
  localparam logic [6:0] A_COMMAND = 7'h17;

  dmi_state_t           r_dmi_state;
  eng_state_t           r_eng_state;
  logic                 r_rsp_valid;
  logic [31:0]          r_rsp_data;
  logic [1:0]           r_rsp_op;
  logic [31:0]          r_data0;
  logic                 r_dmactive;
  logic                 r_haltreq;
  logic [9:0]           r_hartsel;
  logic [2:0]           r_cmderr;
  logic [NUM_HARTS-1:0] r_halted;
  logic [NUM_HARTS-1:0] r_resume_pending;
  logic [NUM_HARTS-1:0] r_resumeack;
  logic [NUM_HARTS-1:0] r_cmd_sel;
  logic [REGADDR_W-1:0] r_cmd_addr;
  logic                 r_cmd_wr;
  logic [31:0]          r_tmo_cnt;

  logic                 w_accept;
  logic                 w_busy;
  logic                 w_abort;
  logic                 w_sel_exists;
  logic                 w_sel_halted;
  logic                 w_sel_running;
  logic                 w_sel_resumeack;
  logic [NUM_HARTS-1:0] w_sel_onehot;
  logic [NUM_HARTS-1:0] w_wr_onehot;
  logic [NUM_HARTS-1:0] w_resume_hit;
  logic [31:0]          w_dmstatus;
  logic [31:0]          w_rd_data;

  assign w_accept = dmi_req_valid_i && (r_dmi_state == S_IDLE);
  assign w_busy   = (r_eng_state == E_ACC);
  assign w_abort  = w_accept && (dmi_req_op_i == 2'd2) &&
                    (dmi_req_address_i == A_DMCTRL) && !dmi_req_data_i[0];

  // Hart decode by comparison so hartsel values beyond NUM_HARTS never index out of range.
  always_comb begin
    w_sel_onehot = '0;
    w_wr_onehot  = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      w_sel_onehot[h] = (r_hartsel == 10'(h));
      w_wr_onehot[h]  = (dmi_req_data_i[25:16] == 10'(h));
    end
  end

  assign w_sel_exists    = ({22'd0, r_hartsel} < 32'(NUM_HARTS));
  assign w_sel_halted    = |(w_sel_onehot & r_halted);
  assign w_sel_running   = w_sel_exists && !w_sel_halted;
  assign w_sel_resumeack = |(w_sel_onehot & r_resumeack);
  assign w_resume_hit    = w_wr_onehot & r_halted;

  assign w_dmstatus = {14'd0, {2{w_sel_resumeack}}, {2{!w_sel_exists}}, 2'b00,
                       {2{w_sel_running}}, {2{w_sel_halted}}, 4'd0, 4'd2};

  always_comb begin
    w_rd_data = '0;
    case (dmi_req_address_i)
      A_DATA0:  w_rd_data = r_data0;
      A_DMCTRL: w_rd_data = {r_haltreq, 1'b0, 4'd0, r_hartsel, 15'd0, r_dmactive};
      A_DMSTAT: w_rd_data = w_dmstatus;
      A_ABSCS:  w_rd_data = {19'd0, w_busy, 1'b0, r_cmderr, 4'd0, 4'd1};
      default:  w_rd_data = '0;
    endcase
  end

  assign dmi_req_ready_o   = (r_dmi_state == S_IDLE);
  assign dmi_rsp_valid_o   = r_rsp_valid;
  assign dmi_rsp_data_o    = r_rsp_data;
  assign dmi_rsp_op_o      = r_rsp_op;
  assign hart_halt_req_o   = (r_dmactive && r_haltreq) ? (w_sel_onehot & ~r_halted) : '0;
  assign hart_resume_req_o = r_dmactive ? r_resume_pending : '0;
  assign hart_reg_en_o     = w_busy;
  assign hart_reg_wr_o     = w_busy && r_cmd_wr;
  assign hart_reg_sel_o    = w_busy ? r_cmd_sel : '0;
  assign hart_reg_addr_o   = w_busy ? r_cmd_addr : '0;
  assign hart_reg_wdata_o  = w_busy ? r_data0 : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_dmi_state      <= S_IDLE;
      r_eng_state      <= E_IDLE;
      r_rsp_valid      <= 1'b0;
      r_rsp_data       <= '0;
      r_rsp_op         <= '0;
      r_data0          <= '0;
      r_dmactive       <= 1'b0;
      r_haltreq        <= 1'b0;
      r_hartsel        <= '0;
      r_cmderr         <= '0;
      r_halted         <= '0;
      r_resume_pending <= '0;
      r_resumeack      <= '0;
      r_cmd_sel        <= '0;
      r_cmd_addr       <= '0;
      r_cmd_wr         <= 1'b0;
      r_tmo_cnt        <= '0;
    end else begin
      r_rsp_valid      <= 1'b0;
      r_halted         <= (r_halted | hart_halt_ack_i) & ~hart_resume_ack_i;
      r_resume_pending <= r_resume_pending & ~hart_resume_ack_i;
      r_resumeack      <= r_resumeack | hart_resume_ack_i;

      case (r_dmi_state)
        S_IDLE: if (w_accept) begin
          r_dmi_state <= S_RSP;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= '0;
          r_rsp_op    <= 2'd0;
          if (dmi_req_op_i == 2'd3) begin
            r_rsp_op <= 2'd2;
          end else if (dmi_req_op_i == 2'd1) begin
            r_rsp_data <= w_rd_data;
          end else if (dmi_req_op_i == 2'd2) begin
            if (dmi_req_address_i == A_DMCTRL) begin
              r_dmactive <= dmi_req_data_i[0];
              r_haltreq  <= dmi_req_data_i[31];
              r_hartsel  <= dmi_req_data_i[25:16];
              if (!dmi_req_data_i[0]) begin
                r_eng_state <= E_IDLE;
              end else if (dmi_req_data_i[30] && !dmi_req_data_i[31]) begin
                r_resume_pending <= (r_resume_pending & ~hart_resume_ack_i) | w_resume_hit;
                r_resumeack      <= (r_resumeack | hart_resume_ack_i) & ~w_resume_hit;
              end
            end else if (r_dmactive) begin
              case (dmi_req_address_i)
                A_DATA0: begin
                  if (!w_busy) r_data0 <= dmi_req_data_i;
                  else if (r_cmderr == 3'd0) r_cmderr <= 3'd1;
                end
                A_ABSCS: r_cmderr <= r_cmderr & ~dmi_req_data_i[10:8];
                A_COMMAND: begin
                  if (w_busy) begin
                    if (r_cmderr == 3'd0) r_cmderr <= 3'd1;
                  end else if (r_cmderr != 3'd0) begin
                    r_cmderr <= r_cmderr;
                  end else if (dmi_req_data_i[31:24] != 8'd0 || dmi_req_data_i[22:20] != 3'd2) begin
                    r_cmderr <= 3'd2;
                  end else if (!w_sel_exists || !w_sel_halted) begin
                    r_cmderr <= 3'd4;
                  end else if (dmi_req_data_i[17]) begin
                    r_eng_state <= E_ACC;
                    r_tmo_cnt   <= '0;
                    r_cmd_sel   <= w_sel_onehot;
                    r_cmd_addr  <= dmi_req_data_i[REGADDR_W-1:0];
                    r_cmd_wr    <= dmi_req_data_i[16];
                  end
                end
                default: ;
              endcase
            end
          end
        end
        S_RSP: r_dmi_state <= S_IDLE;
        default: r_dmi_state <= S_IDLE;
      endcase

      // Engine completion wins over a same-cycle cmderr update from DMI; deactivation wins over both.
      if (w_busy && !w_abort) begin
        if (hart_reg_done_i) begin
          if (!r_cmd_wr) r_data0 <= hart_reg_rdata_i;
          r_eng_state <= E_IDLE;
        end else if (r_tmo_cnt == 32'(TIMEOUT - 1)) begin
          r_eng_state <= E_IDLE;
          r_cmderr    <= 3'd3;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_multi_hart_ctrl.sv
// tb/tb_dm_multi_hart_ctrl.sv - directed self-checking bench for dm_multi_hart_ctrl
module tb_dm_multi_hart_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  dmi_req_op_i;
  logic [31:0] dmi_req_data_i;
  logic [6:0]  dmi_req_address_i;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  logic        dmi_rsp_valid_o;
  logic [31:0] dmi_rsp_data_o;
  logic [1:0]  dmi_rsp_op_o;
  logic [3:0]  hart_halt_req_o;
  logic [3:0]  hart_halt_ack_i;
  logic [3:0]  hart_resume_req_o;
  logic [3:0]  hart_resume_ack_i;
  logic        hart_reg_en_o;
  logic        hart_reg_wr_o;
  logic [3:0]  hart_reg_sel_o;
  logic [15:0] hart_reg_addr_o;
  logic [31:0] hart_reg_wdata_o;
  logic [31:0] hart_reg_rdata_i;
  logic        hart_reg_done_i;

  int n_tests = 0;
  int n_fail  = 0;

  dm_multi_hart_ctrl #(.NUM_HARTS(4), .REGADDR_W(16), .TIMEOUT(255)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dmi_req_op_i(dmi_req_op_i), .dmi_req_data_i(dmi_req_data_i),
    .dmi_req_address_i(dmi_req_address_i), .dmi_req_valid_i(dmi_req_valid_i),
    .dmi_req_ready_o(dmi_req_ready_o), .dmi_rsp_valid_o(dmi_rsp_valid_o),
    .dmi_rsp_data_o(dmi_rsp_data_o), .dmi_rsp_op_o(dmi_rsp_op_o),
    .hart_halt_req_o(hart_halt_req_o), .hart_halt_ack_i(hart_halt_ack_i),
    .hart_resume_req_o(hart_resume_req_o), .hart_resume_ack_i(hart_resume_ack_i),
    .hart_reg_en_o(hart_reg_en_o), .hart_reg_wr_o(hart_reg_wr_o),
    .hart_reg_sel_o(hart_reg_sel_o), .hart_reg_addr_o(hart_reg_addr_o),
    .hart_reg_wdata_o(hart_reg_wdata_o), .hart_reg_rdata_i(hart_reg_rdata_i),
    .hart_reg_done_i(hart_reg_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata, output logic [1:0] rop);
    int n;
    n = 0;
    @(posedge clk_i); #1;
    dmi_req_valid_i   = 1'b1;
    dmi_req_op_i      = op;
    dmi_req_address_i = addr;
    dmi_req_data_i    = data;
    while (!dmi_req_ready_o && n < 8) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_eq("req_ready", {31'd0, dmi_req_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0;
    dmi_req_op_i    = 2'd0;
    check_eq("rsp_valid", {31'd0, dmi_rsp_valid_o}, 32'd1);
    rdata = dmi_rsp_data_o;
    rop   = dmi_rsp_op_o;
  endtask

  task automatic dmi_read(input string tag, input logic [6:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  o;
    dmi_xfer(2'd1, addr, 32'd0, d, o);
    check_eq(tag, d, exp);
    check_eq({tag, "_op"}, {30'd0, o}, 32'd0);
  endtask

  task automatic dmi_write(input logic [6:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic [1:0]  o;
    dmi_xfer(2'd2, addr, data, d, o);
    check_eq("wr_rsp", {d[29:0], o}, 32'd0);
  endtask

  task automatic pulse_halt(input int h);
    @(posedge clk_i); #1;
    hart_halt_ack_i[h] = 1'b1;
    @(posedge clk_i); #1;
    hart_halt_ack_i = '0;
  endtask

  task automatic pulse_resume(input int h);
    @(posedge clk_i); #1;
    hart_resume_ack_i[h] = 1'b1;
    @(posedge clk_i); #1;
    hart_resume_ack_i = '0;
  endtask

  task automatic pulse_done(input logic [31:0] rd);
    @(posedge clk_i); #1;
    hart_reg_done_i  = 1'b1;
    hart_reg_rdata_i = rd;
    @(posedge clk_i); #1;
    hart_reg_done_i  = 1'b0;
    hart_reg_rdata_i = '0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  o;
    reset_i = 1'b1;
    dmi_req_op_i = '0; dmi_req_data_i = '0; dmi_req_address_i = '0; dmi_req_valid_i = 1'b0;
    hart_halt_ack_i = '0; hart_resume_ack_i = '0;
    hart_reg_rdata_i = '0; hart_reg_done_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    check_eq("rst_halt_req", {28'd0, hart_halt_req_o}, 32'd0);
    check_eq("rst_resume_req", {28'd0, hart_resume_req_o}, 32'd0);
    check_eq("rst_reg_en", {31'd0, hart_reg_en_o}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, dmi_rsp_valid_o}, 32'd0);
    dmi_read("rst_abscs", 7'h16, 32'h0000_0001);
    dmi_read("rst_dmstatus", 7'h11, 32'h0000_0C02);

    // halt hart 0
    dmi_write(7'h10, 32'h8000_0001);
    check_eq("halt_req_h0", {28'd0, hart_halt_req_o}, 32'h1);
    @(posedge clk_i); #1;
    check_eq("rsp_strobe_drop", {31'd0, dmi_rsp_valid_o}, 32'd0);
    pulse_halt(0);
    check_eq("halt_req_drop", {28'd0, hart_halt_req_o}, 32'h0);
    dmi_read("dmstatus_h0_halted", 7'h11, 32'h0000_0302);
    dmi_read("dmcontrol_rd", 7'h10, 32'h8000_0001);

    // resume hart 2
    dmi_write(7'h10, 32'h8002_0001);
    check_eq("halt_req_h2", {28'd0, hart_halt_req_o}, 32'h4);
    pulse_halt(2);
    dmi_write(7'h10, 32'h4002_0001);
    check_eq("resume_req_h2", {28'd0, hart_resume_req_o}, 32'h4);
    repeat (2) @(posedge clk_i);
    #1 check_eq("resume_req_hold", {28'd0, hart_resume_req_o}, 32'h4);
    pulse_resume(2);
    check_eq("resume_req_drop", {28'd0, hart_resume_req_o}, 32'h0);
    dmi_read("dmstatus_h2_resumed", 7'h11, 32'h0003_0C02);

    // abstract register read on hart 1
    dmi_write(7'h10, 32'h8001_0001);
    pulse_halt(1);
    dmi_write(7'h17, 32'h0022_1005);
    check_eq("acc_en", {31'd0, hart_reg_en_o}, 32'd1);
    check_eq("acc_sel", {28'd0, hart_reg_sel_o}, 32'h2);
    check_eq("acc_addr", {16'd0, hart_reg_addr_o}, 32'h1005);
    check_eq("acc_wr", {31'd0, hart_reg_wr_o}, 32'd0);
    dmi_read("abscs_busy", 7'h16, 32'h0000_1001);
    check_eq("acc_addr_stable", {16'd0, hart_reg_addr_o}, 32'h1005);
    pulse_done(32'hDEAD_BEEF);
    check_eq("acc_en_drop", {31'd0, hart_reg_en_o}, 32'd0);
    dmi_read("data0_loaded", 7'h04, 32'hDEAD_BEEF);
    dmi_read("abscs_idle", 7'h16, 32'h0000_0001);

    // command to a running hart, then W1C clear
    dmi_write(7'h10, 32'h0003_0001);
    dmi_write(7'h17, 32'h0022_1000);
    dmi_read("cmderr_running", 7'h16, 32'h0000_0401);
    dmi_write(7'h16, 32'h0000_0700);
    dmi_read("cmderr_cleared", 7'h16, 32'h0000_0001);

    // abstract write, second command and data0 write while busy
    dmi_write(7'h10, 32'h0001_0001);
    dmi_write(7'h17, 32'h0023_1001);
    check_eq("accw_wr", {31'd0, hart_reg_wr_o}, 32'd1);
    check_eq("accw_wdata", hart_reg_wdata_o, 32'hDEAD_BEEF);
    dmi_write(7'h17, 32'h0022_1002);
    dmi_write(7'h04, 32'h1234_5678);
    check_eq("accw_wdata_stable", hart_reg_wdata_o, 32'hDEAD_BEEF);
    dmi_read("cmderr_busy", 7'h16, 32'h0000_1101);
    pulse_done(32'h0BAD_0BAD);
    dmi_read("data0_after_write_cmd", 7'h04, 32'hDEAD_BEEF);
    dmi_write(7'h16, 32'h0000_0700);

    // timeout
    dmi_write(7'h17, 32'h0022_1002);
    repeat (254) @(posedge clk_i);
    #1 check_eq("tmo_en_before", {31'd0, hart_reg_en_o}, 32'd1);
    @(posedge clk_i); #1;
    check_eq("tmo_en_after", {31'd0, hart_reg_en_o}, 32'd0);
    dmi_read("cmderr_timeout", 7'h16, 32'h0000_0301);
    dmi_write(7'h16, 32'h0000_0700);

    // nonexistent hart
    dmi_write(7'h10, 32'h8005_0001);
    check_eq("nx_halt_req", {28'd0, hart_halt_req_o}, 32'h0);
    dmi_read("nx_dmstatus", 7'h11, 32'h0000_C002);
    dmi_write(7'h17, 32'h0022_1000);
    dmi_read("nx_cmderr", 7'h16, 32'h0000_0401);
    dmi_write(7'h16, 32'h0000_0700);

    // op encodings and unmapped/WO reads
    dmi_xfer(2'd3, 7'h04, 32'hFFFF_FFFF, d, o);
    check_eq("op3_rsp", {d[29:0], o}, 32'h2);
    dmi_read("data0_after_op3", 7'h04, 32'hDEAD_BEEF);
    dmi_xfer(2'd0, 7'h04, 32'd0, d, o);
    check_eq("nop_rsp", {d[29:0], o}, 32'h0);
    dmi_read("unmapped_rd", 7'h20, 32'h0);
    dmi_read("command_rd", 7'h17, 32'h0);

    // dmactive=0 forces outputs and blocks register writes
    dmi_write(7'h10, 32'h8003_0001);
    check_eq("halt_req_h3", {28'd0, hart_halt_req_o}, 32'h8);
    dmi_write(7'h10, 32'h8003_0000);
    check_eq("inactive_halt_req", {28'd0, hart_halt_req_o}, 32'h0);
    dmi_write(7'h04, 32'h1111_1111);
    dmi_write(7'h10, 32'h0001_0001);
    dmi_read("inactive_data0", 7'h04, 32'hDEAD_BEEF);

    // reset while busy
    dmi_write(7'h17, 32'h0022_1003);
    check_eq("busy_before_reset", {31'd0, hart_reg_en_o}, 32'd1);
    @(posedge clk_i); #1 reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("rst_mid_en", {31'd0, hart_reg_en_o}, 32'd0);
    check_eq("rst_mid_sel", {28'd0, hart_reg_sel_o}, 32'd0);
    check_eq("rst_mid_rsp", {31'd0, dmi_rsp_valid_o}, 32'd0);
    reset_i = 1'b0;
    dmi_read("rst_mid_abscs", 7'h16, 32'h0000_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_multi_hart_ctrl.md
Name: dm_multi_hart_ctrl

Overview:
Parametrised next-generation debug module core. Serves one DMI request/response channel and fans debug control out to NUM_HARTS cores. Provides per-hart halt/resume handshakes, hart selection, status aggregation, and a background abstract-command engine for register access with timeout and error reporting. Sits between the DMI front end and the core array; drop-in replacement for the single-hart debug module.

Parameters:
NUM_HARTS, 4, number of cores controlled (1..1024)
REGADDR_W, 16, width of hart register address (abstract regno)
TIMEOUT, 255, max cycles waiting on hart_reg_done_i before abort

Ports:
clk_i  in  1  clock; all logic on rising edge
reset_i  in  1  synchronous active-high reset
dmi_req_op_i  in  2  0=nop, 1=read, 2=write, 3=reserved
dmi_req_data_i  in  32  write data
dmi_req_address_i  in  7  DM register address
dmi_req_valid_i  in  1  request valid
dmi_req_ready_o  out  1  request accepted when valid&&ready
dmi_rsp_valid_o  out  1  one-cycle response strobe
dmi_rsp_data_o  out  32  read data (0 for writes)
dmi_rsp_op_o  out  2  0=success, 2=failed
hart_halt_req_o  out  NUM_HARTS  per-hart halt request level
hart_halt_ack_i  in  NUM_HARTS  per-hart one-cycle halted pulse
hart_resume_req_o  out  NUM_HARTS  per-hart resume request level
hart_resume_ack_i  in  NUM_HARTS  per-hart one-cycle resumed pulse
hart_reg_en_o  out  1  register access active
hart_reg_wr_o  out  1  1=write, 0=read
hart_reg_sel_o  out  NUM_HARTS  one-hot target hart
hart_reg_addr_o  out  REGADDR_W  register number
hart_reg_wdata_o  out  32  write data
hart_reg_rdata_i  in  32  read data, valid with done
hart_reg_done_i  in  1  one-cycle access-complete pulse

Behaviour:
- Clock is clk_i; reset is synchronous, active-high on reset_i. All outputs 0 after reset. All registers 0 except abstractcs.datacount=1.
- DMI FSM has states IDLE and RSP. dmi_req_ready_o=1 only in IDLE.
- Accept on valid&&ready: IDLE->RSP. Next cycle dmi_rsp_valid_o=1 for exactly 1 cycle, then RSP->IDLE. Back-to-back throughput is one request per 2 cycles.
- Register map:
  - 0x04 data0: RW.
  - 0x10 dmcontrol: [31] haltreq, [30] resumereq, [25:16] hartsel, [0] dmactive.
  - 0x11 dmstatus: RO.
  - 0x16 abstractcs: [12] busy, [10:8] cmderr (W1C), [3:0] datacount=1.
  - 0x17 command: WO, reads 0.
- Unmapped address: read returns 0, op 0; write ignored. Op 3 returns op 2, no side effect. Nop returns op 0, data 0.
- dmactive=0: hart_* outputs forced 0. Writes to other registers are ignored. An in-flight command is aborted and busy cleared.
- hartsel >= NUM_HARTS: hart is nonexistent. dmstatus[14]=[15]=1. Halt, resume and commands to it are no-ops; a command sets cmderr=4.
- halted[h]: set on hart_halt_ack_i[h], cleared on hart_resume_ack_i[h]. If both pulse in the same cycle, resume wins.
- hart_halt_req_o[h] = dmactive && haltreq && hartsel==h && !halted[h].
- resumereq=1 written with haltreq=0 to a halted selected hart: sets resume_pending[h] and clears resumeack[h].
  - hart_resume_req_o[h]=resume_pending[h].
  - On hart_resume_ack_i[h]: pending cleared, resumeack[h] set.
  - resumereq to a running hart is ignored.
  - resumereq is not stored; reads as 0.
- dmstatus reflects the selected hart:
  - [9] allhalted, [8] anyhalted, [11] allrunning, [10] anyrunning, [17] allresumeack, [16] anyresumeack.
  - [3:0] version=2.
- Command write, checked in this order:
  - busy=1 -> cmderr=1 if cmderr==0, command dropped.
  - cmderr!=0 -> dropped.
  - cmdtype[31:24]!=0 or aarsize[22:20]!=2 -> cmderr=2.
  - Hart nonexistent or not halted -> cmderr=4.
  - transfer[17]=0 -> completes immediately, no access.
  - Otherwise busy=1 from the next cycle.
- data0 write while busy: ignored, cmderr=1 if 0.
- Engine (ACC state):
  - hart_reg_en_o held with sel/addr/wr/wdata stable until hart_reg_done_i.
  - On done, read commands load data0<=hart_reg_rdata_i. busy and en drop on that same edge.
  - Counter reaching TIMEOUT without done: en drops, busy clears, cmderr=3.
- DMI traffic continues during busy. abstractcs reads reflect live busy.
- reset_i mid-access: en and busy drop in the same cycle; no response is issued.

Test Plan:
- Halt: write 0x10 data=0x8000_0001 (hartsel 0) -> hart_halt_req_o=4'b0001; pulse halt_ack[0] -> req drops, read 0x11 returns [9:8]=2'b11, op 0.
- Resume: hart 2 halted, write 0x10 data=0x4002_0001 -> resume_req_o=4'b0100 until resume_ack[2]; then dmstatus[17:16]=2'b11, [11:10]=2'b11.
- Register read: hart 1 halted, write 0x17 data=0x0022_1005 -> en=1, sel=0010, addr=0x1005, wr=0; done with rdata=0xDEAD_BEEF after 3 cycles -> read 0x04 returns 0xDEAD_BEEF, busy=0.
- Errors:
  - Command to running hart -> abstractcs[10:8]=4.
  - Second command while busy -> cmderr=1.
  - Write 0x0000_0700 to 0x16 -> cmderr=0.
- Timeout: never assert done -> en drops after TIMEOUT=255 cycles, cmderr=3, busy=0.
- Edge cases:
  - hartsel=5 with NUM_HARTS=4 -> dmstatus[15:14]=2'b11, no halt_req.
  - op=3 -> rsp op 2.
  - reset_i during busy -> all outputs 0 next cycle.
